// File: rtl/arb_pkg.sv
// Shared types and constants for the stream round-robin arbiters.
// arb_entry_t is the {id, data} layout of one buffered stream item.
package arb_pkg;

  localparam int ARB_N   = 4;
  localparam int ARB_W   = 32;
  localparam int ARB_IDW = $clog2(ARB_N);

  typedef struct packed {
    logic [ARB_IDW-1:0] id;
    logic [ARB_W-1:0]   data;
  } arb_entry_t;

  // Explicit wrap keeps non-power-of-two requester counts from aliasing.
  function automatic int rr_next(input int g, input int n);
    if (g == n - 1) begin
      return 0;
    end else begin
      return g + 1;
    end
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// scanning upward with wrap from N-1 back to 0.
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  int idx;

  // Scan priority order starting at ptr; the first hit wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int off = 0; off < N; off++) begin
      if (int'(ptr) + off >= N) begin
        idx = int'(ptr) + off - N;
      end else begin
        idx = int'(ptr) + off;
      end
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = IDW'(idx);
        gnt_onehot[idx] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin arbiter feeding one registered valid/ready stage with a
// single skid entry, so ready_out never reaches ready_in combinationally.
module stream_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N   = ARB_N,
  parameter  int W   = ARB_W,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   valid_in,
  output logic [N-1:0]   ready_in,
  input  logic [W-1:0]   data_in [N],
  output logic           valid_out,
  input  logic           ready_out,
  output logic [W-1:0]   data_out,
  output logic [IDW-1:0] id_out
);

  // Same {id, data} layout as arb_entry_t, sized from this instance's N and W.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } entry_t;

  entry_t         main_q;
  entry_t         main_nxt;
  entry_t         skid_q;
  entry_t         skid_nxt;
  entry_t         acc_entry;
  logic           main_valid;
  logic           main_valid_nxt;
  logic           skid_valid;
  logic           skid_valid_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_ptr_nxt;

  logic [N-1:0]   gnt_onehot;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           can_accept;
  logic           accept;
  logic           handshake;

  rr_pick #(.N(N)) u_pick (
    .req        (valid_in),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Acceptance depends only on registered skid occupancy, never on ready_out.
  assign can_accept = !skid_valid && !reset;
  assign accept     = can_accept && gnt_any;
  assign handshake  = main_valid && ready_out;
  assign ready_in   = can_accept ? gnt_onehot : {N{1'b0}};

  assign acc_entry.id   = gnt_idx;
  assign acc_entry.data = data_in[gnt_idx];

  assign valid_out = main_valid;
  assign data_out  = main_q.data;
  assign id_out    = main_q.id;

  // Next-state for pointer, main and skid entries.
  always_comb begin
    main_valid_nxt = main_valid;
    main_nxt       = main_q;
    skid_valid_nxt = skid_valid;
    skid_nxt       = skid_q;
    rr_ptr_nxt     = rr_ptr;

    if (accept) begin
      rr_ptr_nxt = IDW'(rr_next(int'(gnt_idx), N));
    end else begin
      rr_ptr_nxt = rr_ptr;
    end

    if (skid_valid) begin
      // Skid full: ready_in is low, so the only move is skid -> main.
      if (handshake) begin
        main_nxt       = skid_q;
        skid_valid_nxt = 1'b0;
      end else begin
        main_nxt = main_q;
      end
    end else if (!main_valid) begin
      if (accept) begin
        main_nxt       = acc_entry;
        main_valid_nxt = 1'b1;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (handshake) begin
      if (accept) begin
        main_nxt = acc_entry;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      skid_nxt       = acc_entry;
      skid_valid_nxt = 1'b1;
    end else begin
      main_nxt = main_q;
    end
  end

  // State registers with asynchronous reset; in-flight data is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      rr_ptr     <= '0;
    end else begin
      main_valid <= main_valid_nxt;
      main_q     <= main_nxt;
      skid_valid <= skid_valid_nxt;
      skid_q     <= skid_nxt;
      rr_ptr     <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed and random bench for stream_rr_arbiter (N=4, W=32) against a
// queue-based reference model of the two-entry output buffer.
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic [N-1:0]  valid_in;
  logic [N-1:0]  ready_in;
  logic [W-1:0]  data_in [N];
  logic          valid_out;
  logic          ready_out;
  logic [W-1:0]  data_out;
  logic [1:0]    id_out;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   id;
  } item_t;

  item_t q[$];
  item_t held;
  int    m_ptr;

  stream_rr_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .id_out    (id_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr   = 0;
    held.d  = 32'h0;
    held.id = 2'd0;
  endtask

  // One clock cycle: check outputs against the model, then advance both.
  task automatic step();
    int         g;
    bit         any;
    bit         hs;
    bit         acc;
    logic [3:0] exp_ready;
    item_t      it;
    #2;
    any = 1'b0;
    g   = 0;
    for (int off = 0; off < N; off++) begin
      int i;
      i = (m_ptr + off) % N;
      if (!any && valid_in[i]) begin
        any = 1'b1;
        g   = i;
      end
    end
    exp_ready = (q.size() < 2 && any) ? (4'b0001 << g) : 4'b0000;
    check("ready_in", {28'h0, ready_in}, {28'h0, exp_ready});
    check("valid_out", {31'h0, valid_out}, {31'h0, q.size() > 0});
    check("data_out", data_out, held.d);
    check("id_out", {30'h0, id_out}, {30'h0, held.id});
    hs  = (q.size() > 0) && ready_out;
    acc = (exp_ready != 4'b0000);
    it.d  = data_in[g];
    it.id = 2'(g);
    @(posedge clk);
    if (hs) void'(q.pop_front());
    if (acc) begin
      q.push_back(it);
      m_ptr = (g + 1) % N;
    end
    if (q.size() > 0) held = q[0];
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    valid_in  = 4'b0000;
    ready_out = 1'b0;
    for (int i = 0; i < N; i++) data_in[i] = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_valid_out", {31'h0, valid_out}, 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_id_out", {30'h0, id_out}, 32'h0);
    check("rst_ready_in", {28'h0, ready_in}, 32'h0);

    // Fairness with all requesters active.
    valid_in  = 4'b1111;
    ready_out = 1'b1;
    for (int i = 0; i < N; i++) data_in[i] = 32'h100 + i;
    step();
    check("fair_first_data", data_out, 32'h100);
    check("fair_first_id", {30'h0, id_out}, 32'h0);
    repeat (4) step();
    check("fair_wrap_data", data_out, 32'h100);
    check("fair_wrap_id", {30'h0, id_out}, 32'h0);

    // Pointer skip: accept 0, then only 0 and 3 request.
    valid_in = 4'b0001;
    step();
    valid_in = 4'b1001;
    step();
    check("skip_first_id", {30'h0, id_out}, 32'h3);
    step();
    check("skip_second_id", {30'h0, id_out}, 32'h0);

    // Single requester streaming.
    valid_in = 4'b0100;
    data_in[2] = 32'hA0;
    step();
    check("single_a0", data_out, 32'hA0);
    data_in[2] = 32'hA1;
    step();
    check("single_a1", data_out, 32'hA1);
    data_in[2] = 32'hA2;
    step();
    check("single_a2", data_out, 32'hA2);
    valid_in = 4'b0000;
    step();

    // Backpressure into the skid entry.
    valid_in   = 4'b0010;
    data_in[1] = 32'hDEAD;
    ready_out  = 1'b1;
    step();
    data_in[1] = 32'hBEEF;
    ready_out  = 1'b0;
    step();
    check("bp_hold_dead", data_out, 32'hDEAD);
    data_in[1] = 32'hCAFE;
    step();
    check("bp_still_dead", data_out, 32'hDEAD);
    ready_out = 1'b1;
    step();
    check("bp_beef", data_out, 32'hBEEF);
    step();
    check("bp_cafe", data_out, 32'hCAFE);
    valid_in = 4'b0000;
    step();

    // Idle: outputs hold, pointer unchanged.
    repeat (5) step();
    check("idle_hold", data_out, 32'hCAFE);
    valid_in = 4'b1111;
    for (int i = 0; i < N; i++) data_in[i] = 32'h200 + i;
    step();
    check("idle_next_grant", {30'h0, id_out}, 32'h2);

    // Fill both entries, then reset asynchronously between edges.
    ready_out = 1'b0;
    repeat (3) step();
    #4;
    reset = 1'b1;
    #1;
    check("arst_valid_out", {31'h0, valid_out}, 32'h0);
    check("arst_ready_in", {28'h0, ready_in}, 32'h0);
    check("arst_data_out", data_out, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready_out = 1'b1;
    step();
    check("arst_first_grant", {30'h0, id_out}, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      valid_in  = 4'($urandom_range(0, 15));
      ready_out = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) data_in[i] = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
